mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- Memory/address stage directly downstream of the datapath controller FSM.
- Consumes its memory-control outputs: mem_cmd, load_pc, reset_pc, load_addr, addr_sel.
- Owns the program counter (PC) and the data address register, and drives the single-port synchronous RAM.
- Decodes memory-mapped I/O (LED register, switch input) and returns read data to the instruction register / datapath write-back mux.

Parameters:
- ADDR_W, 9, word-address width (512 x 16 memory space).
- DATA_W, 16, data word width.
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch input address.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_cmd  in  2  00 NONE, 01 WRITE, 11 READ; 10 is reserved and treated as NONE.
- load_pc  in  1  PC load enable.
- reset_pc  in  1  selects 0 as next PC (else PC+1).
- load_addr  in  1  data address register load enable.
- addr_sel  in  1  1: mem_addr=PC; 0: mem_addr=data address register.
- datapath_out  in  DATA_W  datapath C output; address source and store data.
- switches  in  8  board switch inputs.
- ram_dout  in  DATA_W  RAM read data, valid one cycle after address.
- mem_addr  out  ADDR_W  RAM/IO address (combinational mux).
- ram_we  out  1  RAM write enable.
- ram_din  out  DATA_W  RAM write data.
- read_data  out  DATA_W  decoded read data to IR / vsel mux.
- pc  out  ADDR_W  current PC.
- leds  out  8  LED register.
- bus_err  out  1  sticky unmapped-access flag.

Behaviour:
- Reset (async, any time, including mid-access): pc=0, data address=0, leds=0, bus_err=0, read-source pipeline register=RAM, ram_we=0. read_data then reflects ram_dout.
- PC:
  - On a clock edge with load_pc=1: pc <= reset_pc ? 0 : pc+1, wrapping 9'h1FF -> 0.
  - load_pc=0: pc holds, regardless of reset_pc.
- Data address register: on an edge with load_addr=1, loads datapath_out[ADDR_W-1:0]; upper bits are ignored.
- mem_addr = addr_sel ? pc : data address, combinational.
- RAM region is addr[8]=0.
- Writes (mem_cmd=01):
  - addr[8]=0: ram_we=1 combinationally that cycle; ram_din=datapath_out always.
  - addr==LED_ADDR: ram_we=0; leds <= datapath_out[7:0] at the edge.
  - Any other addr[8]=1: no effect; bus_err <= 1.
- Reads (mem_cmd=11): the RAM returns data one cycle later. A 2-bit source register is captured at every edge where mem_cmd=11:
  - RAM when addr[8]=0.
  - SW when addr==SW_ADDR; switches are sampled into a data register at the same edge.
  - NONE otherwise; bus_err <= 1.
  - The register holds when mem_cmd!=11.
- read_data mux, from the source register: RAM -> ram_dout; SW -> {8'h00, sampled switches}; NONE -> 16'h0000.
- Latency: read data is valid the cycle after the READ command cycle, so the IR load in the second fetch cycle sees the word addressed in the first.
- Simultaneous events:
  - load_pc and load_addr in the same cycle both take effect.
  - A write to LED_ADDR in the same cycle as a read-source change cannot happen, since mem_cmd is single-valued.
  - mem_cmd=10 behaves as NONE: no write, source holds, no bus_err.
- bus_err clears only on reset.
- No internal state machine beyond the registers above; all sequencing comes from the controller.

Test Plan:
- Reset, then load_pc=1/reset_pc=1 for one cycle, then load_pc=1/reset_pc=0 for three cycles -> pc: 0,0,1,2,3.
- pc=9'h1FF, load_pc=1, reset_pc=0 -> pc=0. Then load_pc=0, reset_pc=1 for two cycles -> pc stays 0 and unchanged.
- Store to RAM: datapath_out=16'h0042, load_addr=1; next cycle addr_sel=0, datapath_out=16'hBEEF, mem_cmd=01 -> mem_addr=9'h042, ram_we=1, ram_din=16'hBEEF. Then mem_cmd=11 for one cycle -> the following cycle read_data=16'hBEEF (behavioral RAM model).
- Store to LED: data address=9'h100, datapath_out=16'h12A5, mem_cmd=01 -> ram_we=0, leds=8'hA5 after the edge, bus_err=0.
- Switch read: switches=8'h3C, data address=9'h140, mem_cmd=11 -> next cycle read_data=16'h003C. Then change switches to 8'hFF with mem_cmd=00 -> read_data stays 16'h003C.
- Unmapped access plus async reset: read at 9'h180 -> next cycle read_data=0, bus_err=1. Assert reset mid-cycle -> bus_err, leds, pc = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_interface.sv
// Memory/address stage: owns the PC and data address register, drives the
// single-port synchronous RAM, and decodes the LED / switch I/O windows.
module mem_interface #(
   parameter int                 ADDR_W   = 9,
   parameter int                 DATA_W   = 16,
   parameter logic [ADDR_W-1:0]  LED_ADDR = 9'h100,
   parameter logic [ADDR_W-1:0]  SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic              load_pc,
   input  logic              reset_pc,
   input  logic              load_addr,
   input  logic              addr_sel,
   input  logic [DATA_W-1:0] datapath_out,
   input  logic [7:0]        switches,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   output logic [DATA_W-1:0] read_data,
   output logic [ADDR_W-1:0] pc,
   output logic [7:0]        leds,
   output logic              bus_err
);

   localparam logic [1:0] CMD_WR = 2'b01;
   localparam logic [1:0] CMD_RD = 2'b11;

   typedef enum logic [1:0] {
      SRC_RAM  = 2'd0,
      SRC_SW   = 2'd1,
      SRC_NONE = 2'd2
   } src_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        leds_q, leds_d;
   logic [7:0]        sw_q, sw_d;
   logic              bus_err_q, bus_err_d;
   src_e              src_q, src_d;

   logic in_ram, is_wr, is_rd;

   always_comb begin
      mem_addr  = addr_sel ? pc_q : addr_q;
      in_ram    = ~mem_addr[ADDR_W-1];
      is_wr     = (mem_cmd == CMD_WR);
      is_rd     = (mem_cmd == CMD_RD);

      pc_d      = pc_q;
      addr_d    = addr_q;
      leds_d    = leds_q;
      sw_d      = sw_q;
      bus_err_d = bus_err_q;
      src_d     = src_q;

      if (load_pc)
         pc_d = reset_pc ? '0 : pc_q + 1'b1;
      if (load_addr)
         addr_d = datapath_out[ADDR_W-1:0];

      if (is_wr && !in_ram) begin
         if (mem_addr == LED_ADDR)
            leds_d = datapath_out[7:0];
         else
            bus_err_d = 1'b1;
      end

      // Source register steers next cycle's read_data to match RAM latency.
      if (is_rd) begin
         if (in_ram) begin
            src_d = SRC_RAM;
         end else if (mem_addr == SW_ADDR) begin
            src_d = SRC_SW;
            sw_d  = switches;
         end else begin
            src_d     = SRC_NONE;
            bus_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= '0;
         addr_q    <= '0;
         leds_q    <= '0;
         sw_q      <= '0;
         bus_err_q <= 1'b0;
         src_q     <= SRC_RAM;
      end else begin
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         leds_q    <= leds_d;
         sw_q      <= sw_d;
         bus_err_q <= bus_err_d;
         src_q     <= src_d;
      end
   end

   always_comb begin
      // Gate with reset so no RAM write can slip through mid-access.
      ram_we  = is_wr & in_ram & ~reset;
      ram_din = datapath_out;
      case (src_q)
         SRC_RAM: read_data = ram_dout;
         SRC_SW:  read_data = {{(DATA_W-8){1'b0}}, sw_q};
         default: read_data = '0;
      endcase
   end

   assign pc      = pc_q;
   assign leds    = leds_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: behavioural RAM, spec-level reference model,
// directed test-plan checks and a randomized phase.
module tb_mem_interface;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_cmd = 2'b00;
   logic        load_pc = 1'b0, reset_pc = 1'b0, load_addr = 1'b0, addr_sel = 1'b0;
   logic [15:0] datapath_out = 16'h0;
   logic [7:0]  switches = 8'h0;
   logic [15:0] ram_dout;
   logic [8:0]  mem_addr;
   logic        ram_we;
   logic [15:0] ram_din;
   logic [15:0] read_data;
   logic [8:0]  pc;
   logic [7:0]  leds;
   logic        bus_err;

   logic        clr = 1'b1;
   logic        chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_interface dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .load_pc(load_pc),
      .reset_pc(reset_pc), .load_addr(load_addr), .addr_sel(addr_sel),
      .datapath_out(datapath_out), .switches(switches), .ram_dout(ram_dout),
      .mem_addr(mem_addr), .ram_we(ram_we), .ram_din(ram_din),
      .read_data(read_data), .pc(pc), .leds(leds), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Environment RAM: 256 x 16, synchronous read-first, driven by the DUT.
   logic [15:0] env_ram [256];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) env_ram[i] <= 16'h0;
         ram_dout <= 16'h0;
      end else begin
         if (ram_we) env_ram[mem_addr[7:0]] <= ram_din;
         ram_dout <= env_ram[mem_addr[7:0]];
      end
   end

   // Reference model, in plain integers.
   int          m_pc, m_addr, m_leds, m_err, m_src, m_sw;  // m_src: 0 RAM, 1 SW, 2 NONE
   logic [15:0] m_ram [256];
   logic [15:0] m_rdval;

   function automatic int cur_addr();
      return addr_sel ? m_pc : m_addr;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc <= 0; m_addr <= 0; m_leds <= 0; m_err <= 0; m_src <= 0; m_sw <= 0;
      end else begin
         int a;
         a = cur_addr();
         if (load_pc)   m_pc   <= reset_pc ? 0 : (m_pc + 1) % 512;
         if (load_addr) m_addr <= int'(datapath_out) % 512;
         if (mem_cmd == 2'b01) begin
            if (a == 256)      m_leds <= int'(datapath_out) % 256;
            else if (a >= 256) m_err  <= 1;
         end else if (mem_cmd == 2'b11) begin
            if (a < 256)       m_src <= 0;
            else if (a == 320) begin m_src <= 1; m_sw <= int'(switches); end
            else begin m_src <= 2; m_err <= 1; end
         end
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) m_ram[i] <= 16'h0;
         m_rdval <= 16'h0;
      end else begin
         int a;
         a = cur_addr();
         if (!reset && mem_cmd == 2'b01 && a < 256) m_ram[a] <= datapath_out;
         m_rdval <= m_ram[a % 256];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         int a;
         int er;
         a  = cur_addr();
         er = (m_src == 0) ? int'(m_rdval) : (m_src == 1) ? m_sw : 0;
         chk("mem_addr", 32'(mem_addr), a);
         chk("ram_we", 32'(ram_we), 32'(!reset && mem_cmd == 2'b01 && a < 256));
         chk("ram_din", 32'(ram_din), 32'(datapath_out));
         chk("read_data", 32'(read_data), er);
         chk("pc", 32'(pc), m_pc);
         chk("leds", 32'(leds), m_leds);
         chk("bus_err", 32'(bus_err), m_err);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tick();
      clr = 1'b0;
      chk_en = 1'b1;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_leds", 32'(leds), 0);
      chk("rst_bus_err", 32'(bus_err), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_read_data", 32'(read_data), 0);
      reset = 1'b0;

      // PC sequencing and wrap
      load_pc = 1'b1; reset_pc = 1'b1; tick(); chk("pc_clear", 32'(pc), 0);
      reset_pc = 1'b0;
      tick(); chk("pc_inc1", 32'(pc), 1);
      tick(); chk("pc_inc2", 32'(pc), 2);
      tick(); chk("pc_inc3", 32'(pc), 3);
      tick(508); chk("pc_max", 32'(pc), 32'h1FF);
      tick(); chk("pc_wrap", 32'(pc), 0);
      load_pc = 1'b0; reset_pc = 1'b1; tick(2); chk("pc_hold", 32'(pc), 0);
      reset_pc = 1'b0;

      // RAM store then load
      datapath_out = 16'h0042; load_addr = 1'b1; tick();
      load_addr = 1'b0; addr_sel = 1'b0; datapath_out = 16'hBEEF; mem_cmd = 2'b01; #1;
      chk("st_addr", 32'(mem_addr), 32'h042);
      chk("st_we", 32'(ram_we), 1);
      chk("st_din", 32'(ram_din), 32'hBEEF);
      tick(); mem_cmd = 2'b11; tick(); mem_cmd = 2'b00; #1;
      chk("ld_data", 32'(read_data), 32'hBEEF);

      // LED store
      datapath_out = 16'h0100; load_addr = 1'b1; tick();
      load_addr = 1'b0; datapath_out = 16'h12A5; mem_cmd = 2'b01; #1;
      chk("led_we", 32'(ram_we), 0);
      tick(); mem_cmd = 2'b00;
      chk("led_val", 32'(leds), 32'hA5);
      chk("led_err", 32'(bus_err), 0);

      // Switch read, then sampled value must hold
      switches = 8'h3C; datapath_out = 16'h0140; load_addr = 1'b1; tick();
      load_addr = 1'b0; mem_cmd = 2'b11; tick(); mem_cmd = 2'b00;
      chk("sw_read", 32'(read_data), 32'h003C);
      switches = 8'hFF; tick();
      chk("sw_hold", 32'(read_data), 32'h003C);

      // Unmapped read, then async reset mid-cycle
      datapath_out = 16'h0180; load_addr = 1'b1; load_pc = 1'b1; tick();
      load_addr = 1'b0; load_pc = 1'b0; mem_cmd = 2'b11; tick(); mem_cmd = 2'b00;
      chk("unmap_data", 32'(read_data), 0);
      chk("unmap_err", 32'(bus_err), 1);
      chk("pre_rst_pc", 32'(pc), 1);
      #1 reset = 1'b1; #1;
      chk("async_err", 32'(bus_err), 0);
      chk("async_leds", 32'(leds), 0);
      chk("async_pc", 32'(pc), 0);
      tick(); reset = 1'b0;

      // Randomized phase
      for (int c = 0; c < 4000; c++) begin
         int sel;
         reset     = ($urandom_range(249) == 0);
         mem_cmd   = 2'($urandom_range(3));
         load_pc   = 1'($urandom_range(1));
         reset_pc  = ($urandom_range(15) == 0);
         load_addr = 1'($urandom_range(1));
         addr_sel  = ($urandom_range(3) == 0);
         switches  = 8'($urandom);
         sel       = $urandom_range(4);
         case (sel)
            0, 1:    datapath_out = {7'($urandom), 9'($urandom_range(31))};
            2:       datapath_out = {7'($urandom), 9'h100};
            3:       datapath_out = {7'($urandom), 9'h140};
            default: datapath_out = 16'($urandom);
         endcase
         tick();
      end
      reset = 1'b0; mem_cmd = 2'b00;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
